// File: rtl/step_pkg.sv
// Shared types and default sizes for the step generator, step monitor and motion FSM.
// Latency: n/a (declarations only); backpressure: n/a.
package step_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        DONE,
        STALL
    } step_state_t;

    localparam int STEP_POS_W   = 32;
    localparam int STEP_CNT_W   = 31;
    localparam int STEP_PER_W   = 32;
    localparam int STEP_TIMEOUT = 50_000_000;

endpackage

// File: rtl/step_monitor_if.sv
// Control/status bundle between the motion FSM (master) and the step monitor (slave).
// Latency: wires only; backpressure: none, arm is a single-cycle strobe.
interface step_monitor_if
    import step_pkg::*;
#(
    parameter int POS_W = STEP_POS_W,
    parameter int CNT_W = STEP_CNT_W,
    parameter int PER_W = STEP_PER_W
);
    logic             arm;
    logic [CNT_W-1:0] expect_cnt;
    logic [POS_W-1:0] position;
    logic [CNT_W-1:0] seen_cnt;
    logic [CNT_W-1:0] remaining;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             done;
    logic             stall;

    modport master (
        output arm, expect_cnt,
        input  position, seen_cnt, remaining, period, period_valid, done, stall
    );

    modport slave (
        input  arm, expect_cnt,
        output position, seen_cnt, remaining, period, period_valid, done, stall
    );
endinterface

// File: rtl/step_edge_sync.sv
// Synchronizes step/dir and flags one-cycle rising step edges with dir taken from the same stage.
// Latency: edge valid SYNC_STAGES cycles after step_in rises; backpressure: none.
module step_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic step_in,
    input  logic dir_in,
    output logic step_edge,
    output logic dir
);
    logic [SYNC_STAGES-1:0] step_sync;
    logic [SYNC_STAGES-1:0] dir_sync;
    logic                   step_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_sync <= '0;
            dir_sync  <= '0;
            step_last <= 1'b0;
        end else begin
            step_sync <= {step_sync[SYNC_STAGES-2:0], step_in};
            dir_sync  <= {dir_sync[SYNC_STAGES-2:0], dir_in};
            step_last <= step_sync[SYNC_STAGES-1];
        end
    end

    assign step_edge = step_sync[SYNC_STAGES-1] & ~step_last;
    assign dir       = dir_sync[SYNC_STAGES-1];
endmodule

// File: rtl/step_monitor.sv
// Step/dir receiver: position, armed-move pulse count, stall detect; STEP_MONITOR_PERIOD_EN adds period measurement.
// Latency: step_in rise to position/seen_cnt update SYNC_STAGES+1 cycles; backpressure: none.
module step_monitor
    import step_pkg::*;
#(
    parameter int POS_W       = STEP_POS_W,
    parameter int CNT_W       = STEP_CNT_W,
    parameter int PER_W       = STEP_PER_W,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = STEP_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step_in,
    input  logic          dir_in,
    step_monitor_if.slave mon
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    step_state_t      state, state_nxt;
    logic             step_edge;
    logic             dir;
    logic [POS_W-1:0] position;
    logic [CNT_W-1:0] seen_cnt, seen_nxt;
    logic [CNT_W-1:0] expect_r;
    logic [TMR_W-1:0] timer, timer_nxt;

    step_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .reset     (reset),
        .step_in   (step_in),
        .dir_in    (dir_in),
        .step_edge (step_edge),
        .dir       (dir)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            seen_cnt <= '0;
            expect_r <= '0;
            timer    <= '0;
            position <= '0;
        end else begin
            state    <= state_nxt;
            seen_cnt <= seen_nxt;
            timer    <= timer_nxt;
            if (mon.arm)
                expect_r <= mon.expect_cnt;
            if (step_edge)
                position <= dir ? position + POS_W'(1) : position - POS_W'(1);
        end
    end

    // An edge coincident with arm moves position but is not counted toward the new move.
    always_comb begin
        state_nxt = state;
        seen_nxt  = seen_cnt;
        timer_nxt = timer;
        if (mon.arm) begin
            state_nxt = (mon.expect_cnt == '0) ? DONE : ARMED;
            seen_nxt  = '0;
            timer_nxt = '0;
        end else if (state == ARMED || state == RUN) begin
            if (step_edge) begin
                seen_nxt  = seen_cnt + CNT_W'(1);
                timer_nxt = '0;
                state_nxt = (seen_nxt == expect_r) ? DONE : RUN;
            end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                timer_nxt = TMR_W'(TIMEOUT);
                state_nxt = STALL;
            end else begin
                timer_nxt = timer + TMR_W'(1);
            end
        end
    end

    assign mon.position  = position;
    assign mon.seen_cnt  = seen_cnt;
    assign mon.remaining = (seen_cnt >= expect_r) ? '0 : expect_r - seen_cnt;
    assign mon.done      = (state == DONE);
    assign mon.stall     = (state == STALL);

`ifdef STEP_MONITOR_PERIOD_EN
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] period;
    logic             have_edge;
    logic             period_valid;

    // per_cnt restarts at 1 on an edge so it holds the full edge-to-edge spacing at the next edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            per_cnt      <= '0;
            period       <= '0;
            have_edge    <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            if (step_edge)
                per_cnt <= PER_W'(1);
            else if (per_cnt != '1)
                per_cnt <= per_cnt + PER_W'(1);

            if (mon.arm) begin
                have_edge    <= 1'b0;
                period_valid <= 1'b0;
            end else if (step_edge) begin
                have_edge <= 1'b1;
                if (have_edge) begin
                    period       <= per_cnt;
                    period_valid <= 1'b1;
                end
            end
        end
    end

    assign mon.period       = period;
    assign mon.period_valid = period_valid;
`else
    assign mon.period       = PER_W'(0);
    assign mon.period_valid = 1'b0;
`endif
endmodule

// File: tb/tb_step_monitor.sv
// Bench for step_monitor: vector table for move scenarios, scoreboard on every position update, hand sequences for timing corners.
module tb_step_monitor;
    logic clk = 1'b0;
    logic reset;
    logic step_in;
    logic dir_in;

    always #5 clk = ~clk;

    step_monitor_if #(.POS_W(32), .CNT_W(31), .PER_W(32)) bus ();
    step_monitor_if #(.POS_W(4),  .CNT_W(31), .PER_W(32)) bus4 ();

    step_monitor #(.POS_W(32), .CNT_W(31), .PER_W(32), .SYNC_STAGES(2), .TIMEOUT(100)) dut (
        .clk     (clk),
        .reset   (reset),
        .step_in (step_in),
        .dir_in  (dir_in),
        .mon     (bus.slave)
    );

    step_monitor #(.POS_W(4), .CNT_W(31), .PER_W(32), .SYNC_STAGES(2), .TIMEOUT(100)) dut4 (
        .clk     (clk),
        .reset   (reset),
        .step_in (step_in),
        .dir_in  (dir_in),
        .mon     (bus4.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model of the armed move and position.
    typedef struct {
        logic [31:0] pos;
        logic [30:0] seen;
    } sb_t;
    sb_t sb_q[$];

    logic [31:0] pos_m;
    logic [30:0] seen_m;
    logic [30:0] exp_m;
    bit          active_m;
    bit          mon_skip;

    task automatic model_arm(input logic [30:0] n);
        seen_m   = '0;
        exp_m    = n;
        active_m = (n != 0);
    endtask

    task automatic model_edge(input bit d, input bit count_en);
        sb_t e;
        pos_m = d ? pos_m + 32'd1 : pos_m - 32'd1;
        if (count_en && active_m) begin
            seen_m = seen_m + 31'd1;
            if (seen_m == exp_m) active_m = 0;
        end
        e.pos  = pos_m;
        e.seen = seen_m;
        sb_q.push_back(e);
    endtask

    task automatic do_arm(input logic [30:0] n);
        bus.expect_cnt = n;
        bus.arm        = 1'b1;
        model_arm(n);
        @(negedge clk);
        bus.arm = 1'b0;
    endtask

    task automatic pulse(input bit d, input int low);
        dir_in  = d;
        step_in = 1'b1;
        model_edge(d, 1'b1);
        repeat (4) @(negedge clk);
        step_in = 1'b0;
        repeat (low) @(negedge clk);
    endtask

    // Scoreboard: every position change must match the oldest pending edge.
    logic [31:0] prev_pos;
    initial begin
        prev_pos = '0;
        forever begin
            @(negedge clk);
            if (!mon_skip && bus.position != prev_pos) begin
                check("sb_pending", longint'(sb_q.size() > 0), 1);
                if (sb_q.size() > 0) begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("sb_pos", bus.position, e.pos);
                    check("sb_seen", bus.seen_cnt, e.seen);
                end
            end
            prev_pos = bus.position;
        end
    end

    typedef struct {
        bit          do_arm;
        logic [30:0] cnt;
        bit          d;
        int          npulse;
        logic [31:0] pos;
        logic [30:0] seen;
        logic [30:0] rem;
        bit          done;
        bit          stall;
    } vec_t;
    vec_t vecs[5];

    longint per_exp;
    longint pval_exp;

    initial begin
        vecs[0] = '{1'b1, 31'd5, 1'b1, 5, 32'd5, 31'd5, 31'd0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 31'd3, 1'b0, 3, 32'd2, 31'd3, 31'd0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 31'd0, 1'b0, 2, 32'd0, 31'd3, 31'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 31'd4, 1'b1, 2, 32'd2, 31'd2, 31'd2, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 31'd0, 1'b1, 0, 32'd2, 31'd0, 31'd0, 1'b1, 1'b0};

`ifdef STEP_MONITOR_PERIOD_EN
        per_exp  = 40;
        pval_exp = 1;
`else
        per_exp  = 0;
        pval_exp = 0;
`endif

        step_in = 1'b0;
        dir_in  = 1'b0;
        bus.arm = 1'b0;
        bus.expect_cnt = '0;
        bus4.arm = 1'b0;
        bus4.expect_cnt = '0;
        reset    = 1'b1;
        mon_skip = 1'b1;
        pos_m    = '0;
        model_arm(31'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_skip = 1'b0;

        check("rst_pos", bus.position, 0);
        check("rst_seen", bus.seen_cnt, 0);
        check("rst_rem", bus.remaining, 0);
        check("rst_period", bus.period, 0);
        check("rst_pvalid", bus.period_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_stall", bus.stall, 0);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].do_arm) do_arm(vecs[i].cnt);
            for (int p = 0; p < vecs[i].npulse; p++) pulse(vecs[i].d, 4);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_pos", i), bus.position, vecs[i].pos);
            check($sformatf("v%0d_seen", i), bus.seen_cnt, vecs[i].seen);
            check($sformatf("v%0d_rem", i), bus.remaining, vecs[i].rem);
            check($sformatf("v%0d_done", i), bus.done, vecs[i].done);
            check($sformatf("v%0d_stall", i), bus.stall, vecs[i].stall);
        end

        // done drops the cycle after arm; arm with zero sets done one cycle after arm
        do_arm(31'd3);
        check("arm_clr_done", bus.done, 0);
        do_arm(31'd0);
        check("arm0_done", bus.done, 1);

        // stall exactly TIMEOUT cycles after the last counted edge
        do_arm(31'd2);
        dir_in  = 1'b1;
        step_in = 1'b1;
        model_edge(1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("stall_seen1", bus.seen_cnt, 1);
        step_in = 1'b0;
        repeat (99) @(negedge clk);
        check("stall_early", bus.stall, 0);
        @(negedge clk);
        check("stall_at_to", bus.stall, 1);
        check("stall_rem", bus.remaining, 1);
        check("stall_done", bus.done, 0);
        active_m = 0;

        // period over 40-cycle edge spacing
        do_arm(31'd10);
        pulse(1'b1, 36);
        check("per_valid_first", bus.period_valid, 0);
        pulse(1'b1, 36);
        check("per_value", bus.period, per_exp);
        check("per_valid", bus.period_valid, pval_exp);

        // arm in the same cycle as a synchronized edge
        dir_in  = 1'b1;
        step_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.expect_cnt = 31'd3;
        bus.arm        = 1'b1;
        model_arm(31'd3);
        model_edge(1'b1, 1'b0);
        @(negedge clk);
        bus.arm = 1'b0;
        check("coarm_seen", bus.seen_cnt, 0);
        check("coarm_rem", bus.remaining, 3);
        check("coarm_done", bus.done, 0);
        step_in = 1'b0;
        repeat (4) @(negedge clk);

        // reset in the middle of a move
        do_arm(31'd5);
        pulse(1'b1, 4);
        pulse(1'b1, 4);
        check("mid_seen", bus.seen_cnt, 2);
        mon_skip = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_pos", bus.position, 0);
        check("mid_rst_seen", bus.seen_cnt, 0);
        check("mid_rst_rem", bus.remaining, 0);
        check("mid_rst_period", bus.period, 0);
        check("mid_rst_pvalid", bus.period_valid, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_stall", bus.stall, 0);
        pos_m = '0;
        model_arm(31'd0);
        @(negedge clk);
        mon_skip = 1'b0;

        // 4-bit position wraps from +7 through -8 to -1
        for (int p = 0; p < 7; p++) pulse(1'b1, 4);
        check("wrap_pre", bus4.position, 7);
        for (int p = 0; p < 8; p++) pulse(1'b1, 4);
        check("wrap_pos", bus4.position, 4'hF);
        check("wrap_wide", bus.position, 15);

        repeat (5) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
